// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with a 2-entry skid buffer, flush and occupancy output.
// Define PIPE_CLR_DATA_EN to zero held payloads on rst/flush and to read bubbles as zero.
module pipe_skid_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [1:0]        count_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    logic in_fire;
    logic out_fire;
    logic main_load;
    logic main_from_skid;
    logic skid_load;

    // Handshake qualifiers use only flops, so neither ready nor valid has a comb path through this stage.
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (!rst && !flush) begin
            unique case (state)
                EMPTY: main_load = in_fire;
                ONE: begin
                    main_load = in_fire & out_fire;
                    skid_load = in_fire & ~out_fire;
                end
                TWO: begin
                    main_load      = out_fire;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Control state and registered status outputs live in one FSM block.
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                        count_q     <= 2'd1;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                        count_q    <= 2'd2;
                    end else if (!in_fire && out_fire) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                        count_q     <= 2'd0;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                        count_q    <= 2'd1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    count_q     <= 2'd0;
                end
            endcase
        end
    end

`ifdef PIPE_CLR_DATA_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_load) main_q <= main_from_skid ? skid_q : in_data;
            if (skid_load) skid_q <= in_data;
        end
    end

    assign out_data = out_valid_q ? main_q : '0;
`else
    // NOTE: payload flops carry no reset; the valid state alone says whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (main_load) main_q <= main_from_skid ? skid_q : in_data;
        if (skid_load) skid_q <= in_data;
    end

    assign out_data = main_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and scoreboarded checks for pipe_skid_reg (honours PIPE_CLR_DATA_EN when defined).
module tb_pipe_skid_reg;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        count;

    int checks   = 0;
    int failures = 0;

    pipe_skid_reg #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic ov, input logic ir, input logic [1:0] cnt);
        check({tag, "_out_valid"}, DATA_W'(out_valid), DATA_W'(ov));
        check({tag, "_in_ready"}, DATA_W'(in_ready), DATA_W'(ir));
        check({tag, "_count"}, DATA_W'(count), DATA_W'(cnt));
    endtask

    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] prev_data;
    logic              prev_stall;

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held for two cycles.
        step();
        step();
        check_status("reset", 1'b0, 1'b1, 2'd0);
`ifdef PIPE_CLR_DATA_EN
        check("reset_out_data", out_data, '0);
`endif
        rst = 1'b0;

        // Streaming at full rate.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = DATA_W'(i);
            step();
            check($sformatf("stream_data%0d", i), out_data, DATA_W'(i));
            check_status($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
        end
        in_valid = 1'b0;
        step();
        check_status("stream_drain", 1'b0, 1'b1, 2'd0);

        // Backpressure: A, B fill the stage, C waits upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        check_status("bp_a", 1'b1, 1'b1, 2'd1);
        in_data = 32'hB;
        step();
        check_status("bp_b", 1'b1, 1'b0, 2'd2);
        check("bp_b_data", out_data, 32'hA);
        in_data = 32'hC;
        step();
        check_status("bp_hold", 1'b1, 1'b0, 2'd2);
        check("bp_hold_data", out_data, 32'hA);
        out_ready = 1'b1;
        step();
        check("bp_out_b", out_data, 32'hB);
        check_status("bp_out_b", 1'b1, 1'b1, 2'd1);
        step();
        check("bp_out_c", out_data, 32'hC);
        check_status("bp_out_c", 1'b1, 1'b1, 2'd1);
        in_valid = 1'b0;
        step();
        check_status("bp_drain", 1'b0, 1'b1, 2'd0);

        // Flush while full, with D offered on the same cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data = 32'h22;
        step();
        check_status("fl_full", 1'b1, 1'b0, 2'd2);
        flush   = 1'b1;
        in_data = 32'hDD;
        step();
        check_status("flush", 1'b0, 1'b1, 2'd0);
`ifdef PIPE_CLR_DATA_EN
        check("flush_out_data", out_data, '0);
`endif
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check_status("flush_after", 1'b0, 1'b1, 2'd0);

        // rst and flush together in state ONE, then normal acceptance.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h33;
        step();
        check_status("rf_one", 1'b1, 1'b1, 2'd1);
        rst     = 1'b1;
        flush   = 1'b1;
        in_data = 32'h44;
        step();
        check_status("rf_reset", 1'b0, 1'b1, 2'd0);
`ifdef PIPE_CLR_DATA_EN
        check("rf_out_data", out_data, '0);
`endif
        rst     = 1'b0;
        flush   = 1'b0;
        in_data = 32'h55;
        step();
        check("rf_accept_data", out_data, 32'h55);
        check_status("rf_accept", 1'b1, 1'b1, 2'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check_status("rf_drain", 1'b0, 1'b1, 2'd0);

        // Random traffic against a FIFO scoreboard.
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            @(negedge clk);
            if (count > 2'd2) check("rnd_count_max", DATA_W'(count), 32'd2);
            if (prev_stall) check("rnd_stable", out_data, prev_data);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("rnd_underflow", 32'd0, 32'd1);
                else check("rnd_order", out_data, sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("rnd_level", DATA_W'(count), DATA_W'(sb.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
